d_empn_rd_arb: RTL and testbench

- Parametrised successor of the input-FIFO empty_n/read steering logic.
- Arbitrates one upstream FIFO handshake (empty_n_from_gi, read_for_gi, data) among CH_NUM consumer write modules (input feature, kernel, bias, …).
- Steering is driven by a registered grant FSM with per-grant beat-length counting, not by the master FSM state.
- Sits between the global input FIFO and the write modules, under control of the main controller.

---
 rtl/d_empn_rd_arb.sv | 162 ++++++++++++++++
 tb/tb_d_empn_rd_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/d_empn_rd_arb.sv
// Upstream FIFO empty_n/read steering among CH_NUM consumers, driven by a registered grant FSM.
// Optional per-channel beat totals are enabled with `define D_EMPN_BEAT_CNT_EN.
module d_empn_rd_arb #(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    route_en,
    input  logic                    prio_rr,
    input  logic                    empty_n_from_gi,
    output logic                    read_for_gi,
    input  logic [DATA_W-1:0]       data_from_gi,
    input  logic [CH_NUM-1:0]       ch_req,
    input  logic [CH_NUM*CNT_W-1:0] ch_len,
    output logic [CH_NUM-1:0]       ch_empty_n,
    input  logic [CH_NUM-1:0]       ch_read,
    output logic [DATA_W-1:0]       ch_data,
    output logic [CH_NUM-1:0]       grant,
    output logic                    grant_valid,
    output logic [CH_NUM-1:0]       ch_done,
    output logic [CH_NUM-1:0]       ch_abort
`ifdef D_EMPN_BEAT_CNT_EN
    ,
    output logic [CH_NUM*32-1:0]    ch_beat_total
`endif
);

    localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_r;
    logic [CH_NUM-1:0] grant_r;
    logic [PTR_W-1:0]  gidx_r;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [CNT_W-1:0]  remain_r;
    logic              abort_r;

    logic [CH_NUM-1:0] win_oh_s;
    logic [PTR_W-1:0]  win_idx_s;
    logic              win_any_s;
    logic [CNT_W-1:0]  len_sel_s;
    logic              xfer_s;

    assign len_sel_s = ch_len[gidx_r*CNT_W +: CNT_W];
    assign xfer_s    = (state_r == ST_XFER) & route_en & empty_n_from_gi
                     & ch_read[gidx_r] & (remain_r != {CNT_W{1'b0}});

    // Winner search: fixed priority from index 0, or round-robin starting just after rr_ptr.
    always_comb begin
        int idx_v;
        idx_v     = 0;
        win_oh_s  = '0;
        win_idx_s = '0;
        win_any_s = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (prio_rr) begin
                idx_v = (int'(rr_ptr_r) + 1 + i) % CH_NUM;
            end else begin
                idx_v = i;
            end
            if (!win_any_s && ch_req[idx_v]) begin
                win_any_s        = 1'b1;
                win_oh_s[idx_v]  = 1'b1;
                win_idx_s        = PTR_W'(idx_v);
            end else begin
                win_any_s = win_any_s;
            end
        end
    end

    // Grant FSM with per-grant beat counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            gidx_r   <= '0;
            rr_ptr_r <= '0;
            remain_r <= '0;
            abort_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (route_en && win_any_s) begin
                        grant_r <= win_oh_s;
                        gidx_r  <= win_idx_s;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    remain_r <= len_sel_s;
                    state_r  <= (len_sel_s == {CNT_W{1'b0}}) ? ST_DONE : ST_XFER;
                end
                ST_XFER: begin
                    if (xfer_s) begin
                        remain_r <= remain_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    // A dropped request ends the grant even while stalled; a beat in that cycle still counts.
                    if (!ch_req[gidx_r]) begin
                        abort_r <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (xfer_s && (remain_r == {{(CNT_W-1){1'b0}}, 1'b1})) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rr_ptr_r <= gidx_r;
                    grant_r  <= '0;
                    abort_r  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    grant_r <= '0;
                    abort_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Steer the upstream not-empty flag to the granted channel only during XFER.
    always_comb begin
        ch_empty_n = '0;
        if (state_r == ST_XFER) begin
            ch_empty_n[gidx_r] = route_en & empty_n_from_gi;
        end else begin
            ch_empty_n = '0;
        end
    end

    assign read_for_gi = xfer_s;
    assign ch_data     = data_from_gi;
    assign grant       = grant_r;
    assign grant_valid = (state_r != ST_IDLE);
    assign ch_done     = (state_r == ST_DONE) ? grant_r : '0;
    assign ch_abort    = ((state_r == ST_DONE) && abort_r) ? grant_r : '0;

`ifdef D_EMPN_BEAT_CNT_EN
    logic [31:0] beat_cnt_r [CH_NUM];

    // Saturating per-channel beat totals, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH_NUM; i++) begin
                beat_cnt_r[i] <= 32'd0;
            end
        end else if (xfer_s && (beat_cnt_r[gidx_r] != 32'hFFFF_FFFF)) begin
            beat_cnt_r[gidx_r] <= beat_cnt_r[gidx_r] + 32'd1;
        end
    end

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_total
        assign ch_beat_total[gi*32 +: 32] = beat_cnt_r[gi];
    end
`endif

endmodule

// File: tb/tb_d_empn_rd_arb.sv
// Directed self-checking bench for d_empn_rd_arb (CH_NUM=4, DATA_W=64, CNT_W=16).
module tb_d_empn_rd_arb;

    logic        clk;
    logic        reset;
    logic        route_en;
    logic        prio_rr;
    logic        empty_n_from_gi;
    logic        read_for_gi;
    logic [63:0] data_from_gi;
    logic [3:0]  ch_req;
    logic [63:0] ch_len;
    logic [3:0]  ch_empty_n;
    logic [3:0]  ch_read;
    logic [63:0] ch_data;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [3:0]  ch_done;
    logic [3:0]  ch_abort;
`ifdef D_EMPN_BEAT_CNT_EN
    logic [127:0] ch_beat_total;
`endif

    int n_cmp;
    int n_err;
    int beats;

    d_empn_rd_arb #(.CH_NUM(4), .DATA_W(64), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .route_en        (route_en),
        .prio_rr         (prio_rr),
        .empty_n_from_gi (empty_n_from_gi),
        .read_for_gi     (read_for_gi),
        .data_from_gi    (data_from_gi),
        .ch_req          (ch_req),
        .ch_len          (ch_len),
        .ch_empty_n      (ch_empty_n),
        .ch_read         (ch_read),
        .ch_data         (ch_data),
        .grant           (grant),
        .grant_valid     (grant_valid),
        .ch_done         (ch_done),
        .ch_abort        (ch_abort)
`ifdef D_EMPN_BEAT_CNT_EN
        ,
        .ch_beat_total   (ch_beat_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count upstream read beats as seen at each active edge.
    always @(posedge clk) begin
        if (read_for_gi) beats++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, output logic [3:0] d, output logic [3:0] a);
        logic found;
        found = 1'b0;
        d = 4'd0;
        a = 4'd0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (|ch_done) begin
                d = ch_done;
                a = ch_abort;
                found = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, {127'd0, found}, 128'd1);
    endtask

    logic [3:0] d_v, a_v;
    int         b0;
    logic [3:0] rr_exp [5];
    logic       en_v  [8];
    logic       emp_v [8];
    logic       rd_exp[8];

    initial begin
        n_cmp = 0; n_err = 0; beats = 0;
        reset = 1'b1; route_en = 1'b0; prio_rr = 1'b0; empty_n_from_gi = 1'b0;
        data_from_gi = 64'hDEAD_BEEF_0123_4567; ch_req = 4'd0; ch_len = 64'd0; ch_read = 4'd0;
        step(); step();
        check("rst_grant", {124'd0, grant}, 128'd0);
        check("rst_gvalid", {127'd0, grant_valid}, 128'd0);
        check("rst_read", {127'd0, read_for_gi}, 128'd0);
        check("rst_done", {124'd0, ch_done}, 128'd0);
        check("data_pass", {64'd0, ch_data}, {64'd0, 64'hDEAD_BEEF_0123_4567});
        reset = 1'b0;
        step();

        // Single channel, 3 beats.
        route_en = 1'b1; empty_n_from_gi = 1'b1;
        ch_len = {16'd0, 16'd0, 16'd3, 16'd0};
        ch_req = 4'b0010; ch_read = 4'b0010;
        b0 = beats;
        step();
        check("t1_load_grant", {124'd0, grant}, 128'd2);
        check("t1_load_noread", {127'd0, read_for_gi}, 128'd0);
        step();
        check("t1_xfer_read", {127'd0, read_for_gi}, 128'd1);
        check("t1_empty_n", {124'd0, ch_empty_n}, 128'd2);
        wait_done("t1", d_v, a_v);
        check("t1_done", {124'd0, d_v}, 128'd2);
        check("t1_abort", {124'd0, a_v}, 128'd0);
        check("t1_beats", 128'(beats - b0), 128'd3);
        ch_req = 4'd0;
        step();
        check("t1_grant_clr", {124'd0, grant}, 128'd0);

        // Fixed priority twice, then round-robin.
        ch_len = {16'd2, 16'd2, 16'd2, 16'd2};
        ch_read = 4'b1111; ch_req = 4'b1011;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0001; rr_exp[2] = 4'b0010;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            wait_done($sformatf("arb%0d", k), d_v, a_v);
            check($sformatf("arb%0d_ch", k), {124'd0, d_v}, {124'd0, rr_exp[k]});
            if (k == 1) prio_rr = 1'b1;
        end
        ch_req = 4'd0; prio_rr = 1'b0;
        step(); step();

        // Toggling empty_n and a two-cycle route_en stall, len 4 on ch2.
        ch_len = {16'd0, 16'd4, 16'd0, 16'd0};
        ch_req = 4'b0100; ch_read = 4'b0100;
        step(); step();
        en_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        emp_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        rd_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        b0 = beats;
        for (int k = 0; k < 8; k++) begin
            route_en = en_v[k]; empty_n_from_gi = emp_v[k];
            #1;
            check($sformatf("stall%0d_read", k), {127'd0, read_for_gi}, {127'd0, rd_exp[k]});
            step();
        end
        check("stall_done", {124'd0, ch_done}, 128'd4);
        check("stall_beats", 128'(beats - b0), 128'd4);
        ch_req = 4'd0; route_en = 1'b1; empty_n_from_gi = 1'b1;
        step();

        // Zero length goes straight to DONE with no beats.
        ch_len = 64'd0; ch_req = 4'b1000; ch_read = 4'b1000;
        b0 = beats;
        step();
        check("z_load_grant", {124'd0, grant}, 128'd8);
        step();
        check("z_done", {124'd0, ch_done}, 128'd8);
        check("z_beats", 128'(beats - b0), 128'd0);
        ch_req = 4'd0;
        step();

        // Request drop after 2 of 5 beats.
        ch_len = {16'd0, 16'd0, 16'd0, 16'd5}; ch_req = 4'b0001; ch_read = 4'b0001;
        b0 = beats;
        step(); step(); step(); step();
        ch_req = 4'd0; ch_read = 4'd0;
        #1;
        check("ab_noread", {127'd0, read_for_gi}, 128'd0);
        step();
        check("ab_done", {124'd0, ch_done}, 128'd1);
        check("ab_abort", {124'd0, ch_abort}, 128'd1);
        check("ab_beats", 128'(beats - b0), 128'd2);
        step();
        check("ab_idle_abort", {124'd0, ch_abort}, 128'd0);

        // Reset during XFER.
        ch_len = {16'd0, 16'd0, 16'd5, 16'd0}; ch_req = 4'b0010; ch_read = 4'b0010;
        step(); step(); step();
        check("rx_xfer_read", {127'd0, read_for_gi}, 128'd1);
        reset = 1'b1;
        step();
        check("rx_grant", {124'd0, grant}, 128'd0);
        check("rx_read", {127'd0, read_for_gi}, 128'd0);
        check("rx_done", {124'd0, ch_done}, 128'd0);
        check("rx_gvalid", {127'd0, grant_valid}, 128'd0);
`ifdef D_EMPN_BEAT_CNT_EN
        check("rx_totals", ch_beat_total, 128'd0);
`endif
        ch_req = 4'd0;
        step();
        reset = 1'b0;
        step();
        check("rx_after_done", {124'd0, ch_done}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
